// File: rtl/share_decoder.sv
// ---------------------------------------------------------------------------
// share_decoder
//   Recombines a two-share masked word (share0 ^ share1) through a two-stage
//   valid/ready pipeline. Stage 1 registers each share on its own. Stage 2 is
//   the first point where the two shares meet, so the unmasked value never
//   exists combinationally ahead of a share register.
//
// Optional feature:
//   SHARE_DECODER_REFRESH_EN - adds port_r. Both shares are re-masked with the
//   same fresh randomness as they enter stage 1. The recombined value is
//   unchanged because (a^r)^(b^r) = a^b.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   port_a     [2W-1:0] masked input word, share0 = [W-1:0], share1 = [2W-1:W]
//   in_valid   port_a carries a word
//   in_ready   block accepts port_a this cycle
//   port_r     [W-1:0] refresh randomness (SHARE_DECODER_REFRESH_EN only)
//   port_c     [W-1:0] unmasked word
//   out_valid  port_c is valid
//   out_ready  downstream accepts port_c this cycle
//   port_cnt   [15:0] completed output handshakes, wraps
// ---------------------------------------------------------------------------
module share_decoder #(
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [2*W-1:0] port_a,
   input  logic           in_valid,
   output logic           in_ready,
`ifdef SHARE_DECODER_REFRESH_EN
   input  logic [W-1:0]   port_r,
`endif
   output logic [W-1:0]   port_c,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [15:0]    port_cnt
);

   logic [W-1:0] s0_q, s0_d;
   logic [W-1:0] s1_q, s1_d;
   logic         v1_q, v1_d;
   logic [W-1:0] c_q,  c_d;
   logic         v2_q, v2_d;
   logic [15:0]  cnt_q, cnt_d;
   logic         ld2;
   logic         in_ready_c;

   always_comb begin
      s0_d  = s0_q;
      s1_d  = s1_q;
      v1_d  = v1_q;
      c_d   = c_q;
      v2_d  = v2_q;
      cnt_d = cnt_q;

      // Stage 2 may load whenever it is empty or its word leaves this cycle.
      ld2        = !v2_q || out_ready;
      in_ready_c = !v1_q || ld2;

      // ---- stage 2: first place the two shares are combined ----
      if (ld2) begin
         v2_d = v1_q;
         if (v1_q) begin
            c_d = s0_q ^ s1_q;
         end
      end

      // ---- stage 1: each share kept in its own register ----
      if (in_ready_c) begin
         v1_d = in_valid;
         if (in_valid) begin
`ifdef SHARE_DECODER_REFRESH_EN
            s0_d = port_a[W-1:0]   ^ port_r;
            s1_d = port_a[2*W-1:W] ^ port_r;
`else
            s0_d = port_a[W-1:0];
            s1_d = port_a[2*W-1:W];
`endif
         end
      end

      if (v2_q && out_ready) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s0_q  <= '0;
         s1_q  <= '0;
         v1_q  <= 1'b0;
         c_q   <= '0;
         v2_q  <= 1'b0;
         cnt_q <= 16'd0;
      end else begin
         s0_q  <= s0_d;
         s1_q  <= s1_d;
         v1_q  <= v1_d;
         c_q   <= c_d;
         v2_q  <= v2_d;
         cnt_q <= cnt_d;
      end
   end

   assign in_ready  = in_ready_c;
   assign port_c    = c_q;
   assign out_valid = v2_q;
   assign port_cnt  = cnt_q;

endmodule

// File: tb/tb_share_decoder.sv
// ---------------------------------------------------------------------------
// tb_share_decoder
//   Inputs are driven 1 time unit after each rising edge. Everything is
//   sampled on the falling edge. A queue of expected words (share0^share1)
//   and a handshake counter form the reference model.
// ---------------------------------------------------------------------------
module tb_share_decoder;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           reset;
   logic [2*W-1:0] port_a;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   port_r;
   logic [W-1:0]   port_c;
   logic           out_valid;
   logic           out_ready;
   logic [15:0]    port_cnt;

   int n_cmp = 0;
   int n_err = 0;

   // reference model
   logic [W-1:0] exp_q[$];
   logic [15:0]  cnt_m = 16'd0;
   bit           model_ok = 1'b0;
   bit           prev_stall = 1'b0;
   logic [W-1:0] prev_c;

   // values sampled on the falling edge of the last step
   logic         s_in_ready, s_out_valid;
   logic [W-1:0] s_port_c;

   always #5 clk = ~clk;

   share_decoder #(.W(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .port_a    (port_a),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
`ifdef SHARE_DECODER_REFRESH_EN
      .port_r    (port_r),
`endif
      .port_c    (port_c),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .port_cnt  (port_cnt)
   );

   // One clock cycle: sample and check at the falling edge, advance the
   // model for the coming rising edge, then return 1 unit after that edge.
   task automatic step();
      logic [W-1:0] e;
      @(negedge clk);
      s_in_ready  = in_ready;
      s_out_valid = out_valid;
      s_port_c    = port_c;
      if (model_ok) begin
         n_cmp++;
         if (port_cnt !== cnt_m) begin
            n_err++;
            $display("FAIL cnt_track: got %h expected %h", port_cnt, cnt_m);
         end
         if (prev_stall) begin
            n_cmp++;
            if (port_c !== prev_c) begin
               n_err++;
               $display("FAIL stall_stable: got %h expected %h", port_c, prev_c);
            end
         end
      end
      if (reset) begin
         exp_q.delete();
         cnt_m      = 16'd0;
         model_ok   = 1'b1;
         prev_stall = 1'b0;
      end else begin
         if (model_ok && out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL stale_word: got %h expected none", port_c);
            end else begin
               e = exp_q.pop_front();
               if (port_c !== e) begin
                  n_err++;
                  $display("FAIL out_data: got %h expected %h", port_c, e);
               end
            end
            cnt_m = cnt_m + 16'd1;
         end
         if (in_valid && in_ready)
            exp_q.push_back(port_a[W-1:0] ^ port_a[2*W-1:W]);
         prev_stall = out_valid && !out_ready;
         prev_c     = port_c;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      in_valid  = 1'b1;
      out_ready = 1'b0;
      port_a    = 16'($urandom);
      port_r    = 8'($urandom);
      reset     = 1'b1;
      step();
      step();
      reset    = 1'b0;
      in_valid = 1'b0;
      n_cmp += 4;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
      if (in_ready !== 1'b1)  begin n_err++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
      if (port_cnt !== 16'd0) begin n_err++; $display("FAIL rst_cnt: got %h expected 0000", port_cnt); end
      if (port_c !== 8'h00)   begin n_err++; $display("FAIL rst_port_c: got %h expected 00", port_c); end
   endtask

   task automatic test_single();
      out_ready = 1'b1;
      port_a    = 16'h5A3C;
      port_r    = 8'hC3;
      in_valid  = 1'b1;
      step();
      in_valid = 1'b0;
      port_a   = 16'($urandom);
      n_cmp++;
      if (s_in_ready !== 1'b1) begin n_err++; $display("FAIL single_in_ready: got %b expected 1", s_in_ready); end
      n_cmp++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_early: got %b expected 0", out_valid); end
`ifdef SHARE_DECODER_REFRESH_EN
      n_cmp += 2;
      if (dut.s0_q !== 8'hFF) begin n_err++; $display("FAIL refresh_s0: got %h expected FF", dut.s0_q); end
      if (dut.s1_q !== 8'h99) begin n_err++; $display("FAIL refresh_s1: got %h expected 99", dut.s1_q); end
`endif
      step();
      n_cmp += 2;
      if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b expected 1", out_valid); end
      if (port_c !== 8'h66)   begin n_err++; $display("FAIL single_data: got %h expected 66", port_c); end
      step();
      n_cmp += 2;
      if (port_cnt !== 16'd1) begin n_err++; $display("FAIL single_cnt: got %h expected 0001", port_cnt); end
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_drain: got %b expected 0", out_valid); end
   endtask

   task automatic test_stream();
      logic [2*W-1:0] words [4];
      logic [W-1:0]   outs  [4];
      words = '{16'h0000, 16'hFFFF, 16'h00FF, 16'h1234};
      outs  = '{8'h00, 8'h00, 8'hFF, 8'h26};
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_valid = (i < 4);
         port_a   = (i < 4) ? words[i] : 16'($urandom);
         port_r   = 8'($urandom);
         step();
         if (i < 4) begin
            n_cmp++;
            if (s_in_ready !== 1'b1) begin n_err++; $display("FAIL stream_in_ready[%0d]: got %b expected 1", i, s_in_ready); end
         end
         if (i >= 2) begin
            n_cmp++;
            if (s_out_valid !== 1'b1 || s_port_c !== outs[i-2]) begin
               n_err++;
               $display("FAIL stream_out[%0d]: got v=%b c=%h expected v=1 c=%h", i-2, s_out_valid, s_port_c, outs[i-2]);
            end
         end
      end
      in_valid = 1'b0;
      step();
   endtask

   task automatic fill_two(input logic [2*W-1:0] a, input logic [2*W-1:0] b);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      port_a    = a;
      port_r    = 8'($urandom);
      step();
      port_a    = b;
      port_r    = 8'($urandom);
      step();
   endtask

   task automatic test_stall();
      fill_two(16'h1122, 16'hA55A);
      port_a = 16'h8001;
      for (int i = 0; i < 4; i++) begin
         port_r = 8'($urandom);
         step();
         n_cmp++;
         if (s_in_ready !== 1'b0 || s_out_valid !== 1'b1 || s_port_c !== 8'h33) begin
            n_err++;
            $display("FAIL stall_hold[%0d]: got rdy=%b v=%b c=%h expected rdy=0 v=1 c=33", i, s_in_ready, s_out_valid, s_port_c);
         end
      end
      out_ready = 1'b1;
      step();
      n_cmp++;
      if (s_in_ready !== 1'b1) begin n_err++; $display("FAIL stall_both_hs: got %b expected 1", s_in_ready); end
      in_valid = 1'b0;
      step();
      n_cmp++;
      if (s_out_valid !== 1'b1 || s_port_c !== 8'hFF) begin
         n_err++; $display("FAIL stall_order_b: got v=%b c=%h expected v=1 c=FF", s_out_valid, s_port_c);
      end
      step();
      n_cmp++;
      if (s_out_valid !== 1'b1 || s_port_c !== 8'h81) begin
         n_err++; $display("FAIL stall_order_c: got v=%b c=%h expected v=1 c=81", s_out_valid, s_port_c);
      end
      step();
      n_cmp++;
      if (s_out_valid !== 1'b0) begin n_err++; $display("FAIL stall_dup: got %b expected 0", s_out_valid); end
   endtask

   task automatic test_reset_midstream();
      fill_two(16'h7E00, 16'h0C30);
      do_reset();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n_cmp += 3;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b expected 0", out_valid); end
      if (port_cnt !== 16'd0) begin n_err++; $display("FAIL mid_rst_cnt: got %h expected 0000", port_cnt); end
      if (in_ready !== 1'b1)  begin n_err++; $display("FAIL mid_rst_ready: got %b expected 1", in_ready); end
      for (int i = 0; i < 4; i++) begin
         step();
         n_cmp++;
         if (s_out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_stale[%0d]: got %b expected 0", i, s_out_valid); end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         port_a    = 16'($urandom);
         port_r    = 8'($urandom);
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) step();
      n_cmp++;
      if (exp_q.size() != 0 || out_valid !== 1'b0) begin
         n_err++; $display("FAIL random_drain: got %0d pending v=%b expected 0 pending v=0", exp_q.size(), out_valid);
      end
   endtask

   task automatic test_wrap();
      int guard = 0;
      do_reset();
      in_valid  = 1'b1;
      out_ready = 1'b1;
      while (cnt_m != 16'hFFFF && guard < 70000) begin
         port_a = 16'($urandom);
         port_r = 8'($urandom);
         step();
         guard++;
      end
      n_cmp++;
      if (port_cnt !== 16'hFFFF) begin n_err++; $display("FAIL wrap_preload: got %h expected FFFF (guard %0d)", port_cnt, guard); end
      step();
      n_cmp++;
      if (port_cnt !== 16'h0000) begin n_err++; $display("FAIL wrap_zero: got %h expected 0000", port_cnt); end
      in_valid = 1'b0;
      step();
   endtask

   initial begin
      reset     = 1'b1;
      port_a    = '0;
      port_r    = '0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      test_reset();
      test_single();
      test_stream();
      test_stall();
      test_reset_midstream();
      test_random();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
